// File: rtl/cu_pkg.sv
// Shared compute-unit definitions: ALU opcodes, datapath width and the
// state encoding of the ALU-sharing arbiter.
package cu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [3:0] {
        CU_ADD   = 4'd0,
        CU_SUB   = 4'd1,
        CU_AND   = 4'd2,
        CU_OR    = 4'd3,
        CU_XOR   = 4'd4,
        CU_SLL   = 4'd5,
        CU_SRL   = 4'd6,
        CU_SLT   = 4'd7,
        CU_ERROR = 4'd8
    } cuOPType;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_EXEC,
        ARB_RESP
    } arb_state_t;

    // Encodings at or above CU_ERROR are not real operations.
    function automatic logic op_is_err(cuOPType op);
        return (op >= CU_ERROR);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared by the arbiter; unknown and error
// opcodes produce a zero result.
module alu
    import cu_pkg::*;
(
    input  logic [ALU_W-1:0] inputA,
    input  logic [ALU_W-1:0] inputB,
    input  cuOPType          aluOP,
    output logic [ALU_W-1:0] ALUResult,
    output logic             negative,
    output logic             zero
);

    always_comb begin
        ALUResult = '0;
        case (aluOP)
            CU_ADD:  ALUResult = inputA + inputB;
            CU_SUB:  ALUResult = inputA - inputB;
            CU_AND:  ALUResult = inputA & inputB;
            CU_OR:   ALUResult = inputA | inputB;
            CU_XOR:  ALUResult = inputA ^ inputB;
            CU_SLL:  ALUResult = inputA << inputB[4:0];
            CU_SRL:  ALUResult = inputA >> inputB[4:0];
            CU_SLT:  ALUResult = {{(ALU_W-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
            default: ALUResult = '0;
        endcase
    end

    assign negative = ALUResult[ALU_W-1];
    assign zero     = (ALUResult == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of a single ALU between two requesters, with
// registered operands and a result held until its owner accepts it.
module alu_share_arbiter
    import cu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a [2],
    input  logic [WIDTH-1:0] req_b [2],
    input  cuOPType          req_op [2],
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_negative,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] grant_cnt [2]
);

    arb_state_t       state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    cuOPType          op_q, op_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_negative_q, rsp_negative_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] grant_cnt_q [2];
    logic [CNT_W-1:0] grant_cnt_d [2];

    logic             grant_any;
    logic             grant_idx;
    logic [WIDTH-1:0] alu_result;
    logic             alu_negative;
    logic             alu_zero;

    alu u_alu (
        .inputA    (a_q),
        .inputB    (b_q),
        .aluOP     (op_q),
        .ALUResult (alu_result),
        .negative  (alu_negative),
        .zero      (alu_zero)
    );

    // rr_ptr only breaks ties; a lone valid requester always wins.
    always_comb begin
        grant_any = |req_valid;
        grant_idx = (&req_valid) ? rr_ptr_q : req_valid[1];
        req_ready = 2'b00;
        if ((state_q == ARB_IDLE) && grant_any && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_negative_d = rsp_negative_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_err_d      = rsp_err_q;
        grant_cnt_d    = grant_cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant_any) begin
                    a_d     = req_a[grant_idx];
                    b_d     = req_b[grant_idx];
                    op_d    = req_op[grant_idx];
                    owner_d = grant_idx;
                    if (grant_cnt_q[grant_idx] != '1) begin
                        grant_cnt_d[grant_idx] = grant_cnt_q[grant_idx] + CNT_W'(1);
                    end
                    state_d = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                rsp_data_d     = alu_result;
                rsp_negative_d = alu_negative;
                rsp_zero_d     = alu_zero;
                rsp_err_d      = op_is_err(op_q);
                rsp_valid_d    = 2'b01 << owner_q;
                state_d        = ARB_RESP;
            end
            ARB_RESP: begin
                // The pointer moves only here, so a grant alone never shifts priority.
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    rr_ptr_d    = ~owner_q;
                    state_d     = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ARB_IDLE;
            rr_ptr_q       <= 1'b0;
            owner_q        <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= CU_ADD;
            rsp_valid_q    <= 2'b00;
            rsp_data_q     <= '0;
            rsp_negative_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_err_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_negative_q <= rsp_negative_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_err_q      <= rsp_err_d;
            for (int i = 0; i < 2; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_negative = rsp_negative_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_err      = rsp_err_q;
    assign grant_cnt    = grant_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, fairness, stall, reset
// and saturation sequences, then random traffic against a transaction model.
module tb_alu_share_arbiter;
    import cu_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        neg;
        logic        zero;
        logic        err;
    } res_t;

    typedef struct {
        logic        req_idx;
        cuOPType     op;
        logic [31:0] a;
        logic [31:0] b;
        res_t        exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    cuOPType     req_op [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_negative;
    logic        rsp_zero;
    logic        rsp_err;
    logic [15:0] grant_cnt [2];

    logic [1:0]  req_ready_s;
    logic [1:0]  rsp_valid_s;
    logic [31:0] rsp_data_s;
    logic        rsp_negative_s;
    logic        rsp_zero_s;
    logic        rsp_err_s;
    logic [1:0]  grant_cnt_s [2];

    int checks = 0;
    int errors = 0;

    logic model_pref;
    int   model_cnt [2];

    alu_share_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_negative(rsp_negative), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .grant_cnt(grant_cnt)
    );

    alu_share_arbiter #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_data(rsp_data_s),
        .rsp_negative(rsp_negative_s), .rsp_zero(rsp_zero_s), .rsp_err(rsp_err_s),
        .grant_cnt(grant_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic res_t alu_model(cuOPType op, logic [31:0] a, logic [31:0] b);
        res_t        r;
        int unsigned code;
        code = op;
        case (code)
            0:       r.data = a + b;
            1:       r.data = a - b;
            2:       r.data = a & b;
            3:       r.data = a | b;
            4:       r.data = a ^ b;
            5:       r.data = a << b[4:0];
            6:       r.data = a >> b[4:0];
            7:       r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r.data = 32'd0;
        endcase
        r.err  = (code >= 8);
        r.neg  = r.data[31];
        r.zero = (r.data == 32'd0);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        rsp_ready  = 2'b00;
        model_pref = 1'b0;
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts and ends at a falling edge with the arbiter idle.
    task automatic apply_stimulus(input logic [1:0] mask,
                                  input cuOPType op0, input cuOPType op1,
                                  input logic [31:0] a0, input logic [31:0] b0,
                                  input logic [31:0] a1, input logic [31:0] b1,
                                  input res_t exp0, input res_t exp1,
                                  input int wait_cycles, output logic g);
        logic       exp_g;
        logic [1:0] exp_mask;
        res_t       exp;
        int         sat;
        exp_g    = (&mask) ? model_pref : mask[1];
        exp_mask = 2'b01 << exp_g;
        exp      = exp_g ? exp1 : exp0;
        req_op[0] = op0; req_a[0] = a0; req_b[0] = b0;
        req_op[1] = op1; req_a[1] = a1; req_b[1] = b1;
        req_valid = mask;
        rsp_ready = 2'b00;
        #1;
        check_output("accept_req_ready", req_ready, exp_mask);
        check_output("accept_req_ready_sat", req_ready_s, exp_mask);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        model_cnt[exp_g]++;
        sat = (model_cnt[exp_g] > 3) ? 3 : model_cnt[exp_g];
        @(negedge clk);
        check_output("exec_req_ready", req_ready, 2'b00);
        check_output("exec_rsp_valid", rsp_valid, 2'b00);
        check_output("grant_cnt", grant_cnt[exp_g], model_cnt[exp_g]);
        check_output("grant_cnt_sat", grant_cnt_s[exp_g], sat);
        @(negedge clk);
        check_output("rsp_valid", rsp_valid, exp_mask);
        check_output("rsp_data", rsp_data, exp.data);
        check_output("rsp_negative", rsp_negative, exp.neg);
        check_output("rsp_zero", rsp_zero, exp.zero);
        check_output("rsp_err", rsp_err, exp.err);
        check_output("rsp_data_sat", rsp_data_s, exp.data);
        check_output("rsp_flags_sat", {rsp_valid_s, rsp_negative_s, rsp_zero_s, rsp_err_s},
                     {exp_mask, exp.neg, exp.zero, exp.err});
        for (int i = 0; i < wait_cycles; i++) begin
            req_valid = 2'b11;
            rsp_ready = ~exp_mask;
            @(negedge clk);
            check_output("hold_rsp_valid", rsp_valid, exp_mask);
            check_output("hold_rsp_data", rsp_data, exp.data);
            check_output("hold_flags", {rsp_negative, rsp_zero, rsp_err}, {exp.neg, exp.zero, exp.err});
            check_output("hold_req_ready", req_ready, 2'b00);
        end
        req_valid = 2'b00;
        rsp_ready = exp_mask | (($urandom_range(0, 1) == 1) ? ~exp_mask : 2'b00);
        @(posedge clk);
        #1;
        rsp_ready  = 2'b00;
        model_pref = ~exp_g;
        @(negedge clk);
        check_output("done_rsp_valid", rsp_valid, 2'b00);
        g = exp_g;
    endtask

    vec_t        vecs [11];
    logic        g;
    res_t        e0, e1;
    cuOPType     op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  code0, code1;
    logic [1:0]  mask;

    initial begin
        vecs[0]  = '{req_idx:1'b0, op:CU_ADD, a:32'd10, b:32'd15,
                     exp:'{data:32'd25, neg:1'b0, zero:1'b0, err:1'b0}};
        vecs[1]  = '{req_idx:1'b1, op:CU_SUB, a:32'd5, b:32'd5,
                     exp:'{data:32'd0, neg:1'b0, zero:1'b1, err:1'b0}};
        vecs[2]  = '{req_idx:1'b1, op:CU_SUB, a:32'd3, b:32'd7,
                     exp:'{data:32'hFFFFFFFC, neg:1'b1, zero:1'b0, err:1'b0}};
        vecs[3]  = '{req_idx:1'b0, op:CU_AND, a:32'hF0F0F0F0, b:32'h0FF00FF0,
                     exp:'{data:32'h00F000F0, neg:1'b0, zero:1'b0, err:1'b0}};
        vecs[4]  = '{req_idx:1'b1, op:CU_OR, a:32'h00001200, b:32'h00000034,
                     exp:'{data:32'h00001234, neg:1'b0, zero:1'b0, err:1'b0}};
        vecs[5]  = '{req_idx:1'b0, op:CU_XOR, a:32'hFFFFFFFF, b:32'h00000001,
                     exp:'{data:32'hFFFFFFFE, neg:1'b1, zero:1'b0, err:1'b0}};
        vecs[6]  = '{req_idx:1'b1, op:CU_SLL, a:32'd1, b:32'd31,
                     exp:'{data:32'h80000000, neg:1'b1, zero:1'b0, err:1'b0}};
        vecs[7]  = '{req_idx:1'b0, op:CU_SRL, a:32'h80000000, b:32'd4,
                     exp:'{data:32'h08000000, neg:1'b0, zero:1'b0, err:1'b0}};
        vecs[8]  = '{req_idx:1'b1, op:CU_SLT, a:32'hFFFFFFFF, b:32'd1,
                     exp:'{data:32'd1, neg:1'b0, zero:1'b0, err:1'b0}};
        vecs[9]  = '{req_idx:1'b0, op:CU_ERROR, a:32'd9, b:32'd9,
                     exp:'{data:32'd0, neg:1'b0, zero:1'b1, err:1'b1}};
        vecs[10] = '{req_idx:1'b1, op:cuOPType'(4'hF), a:32'd4, b:32'd2,
                     exp:'{data:32'd0, neg:1'b0, zero:1'b1, err:1'b1}};

        rst       = 1'b1;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_a[i]  = 32'd0;
            req_b[i]  = 32'd0;
            req_op[i] = CU_ADD;
        end
        #3;
        check_output("reset_req_ready", req_ready, 2'b00);
        check_output("reset_rsp_valid", rsp_valid, 2'b00);
        check_output("reset_rsp_data", rsp_data, 32'd0);
        check_output("reset_flags", {rsp_negative, rsp_zero, rsp_err}, 3'b000);
        check_output("reset_grant_cnt", {grant_cnt[0], grant_cnt[1]}, 32'd0);
        apply_reset();

        // Directed vectors, one requester at a time.
        for (int i = 0; i < 11; i++) begin
            mask = 2'b01 << vecs[i].req_idx;
            apply_stimulus(mask, vecs[i].op, vecs[i].op, vecs[i].a, vecs[i].b,
                           vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].exp, i % 3, g);
            check_output("table_grant", g, vecs[i].req_idx);
        end

        // Both requesters always valid: strict alternation starting at 0.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            e0 = alu_model(CU_ADD, a0, b0);
            e1 = alu_model(CU_XOR, a1, b1);
            apply_stimulus(2'b11, CU_ADD, CU_XOR, a0, b0, a1, b1, e0, e1, 0, g);
            check_output("fair_grant", g, i % 2);
        end
        check_output("fair_cnt0", grant_cnt[0], 16'd4);
        check_output("fair_cnt1", grant_cnt[1], 16'd4);

        // Long response stall.
        e0 = alu_model(CU_ADD, 32'd100, 32'd23);
        apply_stimulus(2'b01, CU_ADD, CU_ADD, 32'd100, 32'd23, 32'd0, 32'd0, e0, e0, 5, g);
        check_output("stall_data", e0.data, 32'd123);

        // Reset in the middle of an EXEC cycle.
        req_op[0] = CU_ADD; req_a[0] = 32'd7; req_b[0] = 32'd8;
        req_valid = 2'b01;
        #1;
        check_output("rst_accept", req_ready, 2'b01);
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_pref   = 1'b0;
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        #1;
        check_output("rst_req_ready", req_ready, 2'b00);
        check_output("rst_rsp_valid", rsp_valid, 2'b00);
        check_output("rst_rsp_data", rsp_data, 32'd0);
        check_output("rst_grant_cnt", {grant_cnt[0], grant_cnt[1]}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("post_rst_rsp_valid", rsp_valid, 2'b00);
        end
        e0 = alu_model(CU_SUB, 32'd50, 32'd8);
        e1 = alu_model(CU_OR, 32'd1, 32'd2);
        apply_stimulus(2'b11, CU_SUB, CU_OR, 32'd50, 32'd8, 32'd1, 32'd2, e0, e1, 1, g);
        check_output("post_rst_grant", g, 1'b0);

        // Saturating counter on the narrow-counter instance.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            e0 = alu_model(CU_ADD, i, 1);
            apply_stimulus(2'b01, CU_ADD, CU_ADD, i, 32'd1, 32'd0, 32'd0, e0, e0, 0, g);
        end
        check_output("sat_cnt_narrow", grant_cnt_s[0], 2'd3);
        check_output("sat_cnt_wide", grant_cnt[0], 16'd5);

        // Random traffic against the transaction model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 2'b00;
                #1;
                check_output("idle_req_ready", req_ready, 2'b00);
                check_output("idle_rsp_valid", rsp_valid, 2'b00);
                @(negedge clk);
            end
            mask  = 2'($urandom_range(1, 3));
            code0 = 4'($urandom_range(0, 15));
            code1 = 4'($urandom_range(0, 15));
            op0   = cuOPType'(code0);
            op1   = cuOPType'(code1);
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            e0 = alu_model(op0, a0, b0);
            e1 = alu_model(op1, a1, b1);
            apply_stimulus(mask, op0, op1, a0, b0, a1, b1, e0, e1, $urandom_range(0, 3), g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
